io_seg_display_scan: RTL and testbench

- Downstream consumer of the three 32-bit I/O output-port registers; drives an 8-digit, common-anode seven-segment display.
- A sequential double-dabble converter turns each port value into decimal. A prescaled scan counter then multiplexes the eight digits.
- Display layout, left to right: digits 7-6 = port0 (00-99), digits 5-4 = port1 (00-99), digits 3-0 = port2 (0000-9999).

---
 rtl/io_seg_display_scan.sv | 238 +++++++++++++++++++++++
 tb/tb_io_seg_display_scan.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/io_seg_display_scan.sv
// rtl/io_seg_display_scan.sv - double-dabble converter and 8-digit multiplexed seven-segment scanner
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zeros within each display field.
module io_seg_display_scan #(
    parameter int SCAN_DIV = 50000,
    parameter int PS_W     = 16
) (
    input  logic        clock,
    input  logic        clrn,
    input  logic [31:0] out_port0,
    input  logic [31:0] out_port1,
    input  logic [31:0] out_port2,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_SHIFT = 2'd1,
        S_STORE = 2'd2
    } state_t;

    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    state_t        state_q, state_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [15:0]   bin_q, bin_d;
    logic [19:0]   bcd_q, bcd_d;
    logic          ovf_q, ovf_d;
    logic [3:0]    iter_q, iter_d;

    logic [7:0]    disp0_q, disp0_d;
    logic [7:0]    disp1_q, disp1_d;
    logic [15:0]   disp2_q, disp2_d;
    logic          ovf0_q, ovf0_d;
    logic          ovf1_q, ovf1_d;
    logic          ovf2_q, ovf2_d;

    logic [PS_W-1:0] ps_q, ps_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      an_q, an_d;
    logic [6:0]      seg_q, seg_d;

    logic [15:0]   sel_val;
    logic [19:0]   adj;
    logic          wrap;
    logic [3:0]    dig_nib;
    logic          dig_ovf;
    logic          dig_blank;
    logic          unused_hi;

    assign unused_hi = ^{out_port0[31:16], out_port1[31:16], out_port2[31:16], adj[19]};

    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        case (n)
            4'd0:    seg_decode = 7'b1000000;
            4'd1:    seg_decode = 7'b1111001;
            4'd2:    seg_decode = 7'b0100100;
            4'd3:    seg_decode = 7'b0110000;
            4'd4:    seg_decode = 7'b0011001;
            4'd5:    seg_decode = 7'b0010010;
            4'd6:    seg_decode = 7'b0000010;
            4'd7:    seg_decode = 7'b1111000;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0010000;
            default: seg_decode = SEG_BLANK;
        endcase
    endfunction

    always_comb begin
        case (ptr_q)
            2'd0:    sel_val = out_port0[15:0];
            2'd1:    sel_val = out_port1[15:0];
            default: sel_val = out_port2[15:0];
        endcase
    end

    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < 5; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Converter: display registers change only in STORE, so the scan never sees a partial field.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        ovf_d   = ovf_q;
        iter_d  = iter_q;
        disp0_d = disp0_q;
        disp1_d = disp1_q;
        disp2_d = disp2_q;
        ovf0_d  = ovf0_q;
        ovf1_d  = ovf1_q;
        ovf2_d  = ovf2_q;
        case (state_q)
            S_LOAD: begin
                bin_d   = sel_val;
                bcd_d   = 20'd0;
                ovf_d   = (ptr_q == 2'd2) ? (sel_val > 16'd9999) : (sel_val > 16'd99);
                iter_d  = 4'd0;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                {bcd_d, bin_d} = {adj[18:0], bin_q, 1'b0};
                iter_d = iter_q + 4'd1;
                if (iter_q == 4'd15) begin
                    state_d = S_STORE;
                end
            end
            S_STORE: begin
                case (ptr_q)
                    2'd0: begin
                        disp0_d = bcd_q[7:0];
                        ovf0_d  = ovf_q;
                        ptr_d   = 2'd1;
                    end
                    2'd1: begin
                        disp1_d = bcd_q[7:0];
                        ovf1_d  = ovf_q;
                        ptr_d   = 2'd2;
                    end
                    2'd2: begin
                        disp2_d = bcd_q[15:0];
                        ovf2_d  = ovf_q;
                        ptr_d   = 2'd0;
                    end
                    default: ptr_d = 2'd0;
                endcase
                state_d = S_LOAD;
            end
            default: begin
                state_d = S_LOAD;
                ptr_d   = 2'd0;
            end
        endcase
    end

    always_comb begin
        wrap  = (ps_q == PS_W'(SCAN_DIV - 1));
        ps_d  = wrap ? '0 : ps_q + PS_W'(1);
        idx_d = wrap ? idx_q + 3'd1 : idx_q;
    end

    // Digit 7 is the leftmost; index selects field and nibble for the upcoming slot.
    always_comb begin
        case (idx_d)
            3'd7:    begin dig_nib = disp0_q[7:4];   dig_ovf = ovf0_q; end
            3'd6:    begin dig_nib = disp0_q[3:0];   dig_ovf = ovf0_q; end
            3'd5:    begin dig_nib = disp1_q[7:4];   dig_ovf = ovf1_q; end
            3'd4:    begin dig_nib = disp1_q[3:0];   dig_ovf = ovf1_q; end
            3'd3:    begin dig_nib = disp2_q[15:12]; dig_ovf = ovf2_q; end
            3'd2:    begin dig_nib = disp2_q[11:8];  dig_ovf = ovf2_q; end
            3'd1:    begin dig_nib = disp2_q[7:4];   dig_ovf = ovf2_q; end
            default: begin dig_nib = disp2_q[3:0];   dig_ovf = ovf2_q; end
        endcase
    end

`ifdef LEADING_ZERO_BLANK_EN
    // A digit blanks when it and every more significant digit of its field is zero.
    always_comb begin
        case (idx_d)
            3'd7:    dig_blank = (disp0_q[7:4] == 4'd0);
            3'd5:    dig_blank = (disp1_q[7:4] == 4'd0);
            3'd3:    dig_blank = (disp2_q[15:12] == 4'd0);
            3'd2:    dig_blank = (disp2_q[15:8] == 8'd0);
            3'd1:    dig_blank = (disp2_q[15:4] == 12'd0);
            default: dig_blank = 1'b0;
        endcase
    end
`else
    assign dig_blank = 1'b0;
`endif

    always_comb begin
        an_d  = an_q;
        seg_d = seg_q;
        if (wrap) begin
            an_d = ~(8'b1 << idx_d);
            if (dig_ovf) begin
                seg_d = SEG_DASH;
            end else if (dig_blank) begin
                seg_d = SEG_BLANK;
            end else begin
                seg_d = seg_decode(dig_nib);
            end
        end
    end

    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            state_q <= S_LOAD;
            ptr_q   <= 2'd0;
            bin_q   <= 16'd0;
            bcd_q   <= 20'd0;
            ovf_q   <= 1'b0;
            iter_q  <= 4'd0;
            disp0_q <= 8'd0;
            disp1_q <= 8'd0;
            disp2_q <= 16'd0;
            ovf0_q  <= 1'b0;
            ovf1_q  <= 1'b0;
            ovf2_q  <= 1'b0;
            ps_q    <= '0;
            idx_q   <= 3'd7;
            an_q    <= 8'hFF;
            seg_q   <= 7'h7F;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
            iter_q  <= iter_d;
            disp0_q <= disp0_d;
            disp1_q <= disp1_d;
            disp2_q <= disp2_d;
            ovf0_q  <= ovf0_d;
            ovf1_q  <= ovf1_d;
            ovf2_q  <= ovf2_d;
            ps_q    <= ps_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = 1'b1;

endmodule

// File: tb/tb_io_seg_display_scan.sv
// tb/tb_io_seg_display_scan.sv - scoreboard bench for io_seg_display_scan
module tb_io_seg_display_scan;

    localparam int SCAN_DIV = 3;

    logic        clock = 1'b0;
    logic        clrn;
    logic [31:0] out_port0, out_port1, out_port2;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;

    typedef struct {
        logic [7:0] an;
        logic [6:0] seg;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    io_seg_display_scan #(.SCAN_DIV(SCAN_DIV), .PS_W(4)) dut (
        .clock     (clock),
        .clrn      (clrn),
        .out_port0 (out_port0),
        .out_port1 (out_port1),
        .out_port2 (out_port2),
        .an        (an),
        .seg       (seg),
        .dp        (dp)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] ref_seg(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [6:0] ref_digit(input int idx, input int v0, input int v1, input int v2);
        int v, pos, lim, p10;
        if (idx >= 6) begin v = v0; pos = idx - 6; lim = 99; end
        else if (idx >= 4) begin v = v1; pos = idx - 4; lim = 99; end
        else begin v = v2; pos = idx; lim = 9999; end
        if (v > lim) return 7'b0111111;
        p10 = 1;
        for (int i = 0; i < pos; i++) p10 = p10 * 10;
`ifdef LEADING_ZERO_BLANK_EN
        if (pos > 0 && v < p10) return 7'b1111111;
`endif
        return ref_seg((v / p10) % 10);
    endfunction

    task automatic apply(input logic [31:0] p0, input logic [31:0] p1, input logic [31:0] p2);
        exp_t e;
        out_port0 = p0;
        out_port1 = p1;
        out_port2 = p2;
        for (int idx = 0; idx < 8; idx++) begin
            e.an  = ~(8'b1 << idx);
            e.seg = ref_digit(idx, int'(p0[15:0]), int'(p1[15:0]), int'(p2[15:0]));
            exp_q.push_back(e);
        end
        repeat (72) @(posedge clock);
    endtask

    task automatic scan_frame();
        exp_t e;
        int   guard;
        int   hold;
        guard = 0;
        @(negedge clock);
        while (an == 8'hFE && guard < 100) begin @(negedge clock); guard++; end
        while (an != 8'hFE && guard < 100) begin @(negedge clock); guard++; end
        check("frame_sync", {24'd0, an}, 32'h0000_00FE);
        for (int k = 0; k < 8; k++) begin
            if (exp_q.size() == 0) break;
            e = exp_q.pop_front();
            check($sformatf("an_d%0d", k), {24'd0, an}, {24'd0, e.an});
            check($sformatf("seg_d%0d", k), {25'd0, seg}, {25'd0, e.seg});
            check("dp", {31'd0, dp}, 32'd1);
            hold = 1;
            while (hold < 20) begin
                @(negedge clock);
                if (an !== e.an) break;
                hold++;
            end
            check($sformatf("hold_d%0d", k), hold, SCAN_DIV);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        clrn = 1'b0;
        out_port0 = 32'd0;
        out_port1 = 32'd0;
        out_port2 = 32'd0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_an", {24'd0, an}, 32'h0000_00FF);
        check("rst_seg", {25'd0, seg}, 32'h0000_007F);
        check("rst_dp", {31'd0, dp}, 32'd1);

        clrn = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("pre_wrap_an", {24'd0, an}, 32'h0000_00FF);
        @(posedge clock);
        @(negedge clock);
        check("first_wrap_an", {24'd0, an}, 32'h0000_00FE);
        check("first_wrap_seg", {25'd0, seg}, {25'd0, 7'b1000000});

        apply(32'd42, 32'd7, 32'd1234);
        scan_frame();
        apply(32'd105, 32'd56, 32'd10000);
        scan_frame();
        apply(32'd99, 32'd100, 32'd9999);
        scan_frame();
        apply(32'hABCD_0005, 32'd0, 32'd65535);
        scan_frame();
        apply(32'd0, 32'h0001_0003, 32'd7);
        scan_frame();

        // Reset pulse between edges, then a port2 change during its SHIFT.
        out_port0 = 32'd42;
        out_port1 = 32'd7;
        out_port2 = 32'd5;
        @(posedge clock);
        #2 clrn = 1'b0;
        #1;
        check("async_rst_an", {24'd0, an}, 32'h0000_00FF);
        check("async_rst_seg", {25'd0, seg}, 32'h0000_007F);
        check("async_rst_dp", {31'd0, dp}, 32'd1);
        @(negedge clock);
        clrn = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("post_rst_an", {24'd0, an}, 32'h0000_00FE);
        check("post_rst_zero", {25'd0, seg}, {25'd0, 7'b1000000});
        repeat (37) @(posedge clock);
        #1 out_port2 = 32'd9;
        repeat (35) @(posedge clock);
        @(negedge clock);
        check("snap_an", {24'd0, an}, 32'h0000_00FE);
        check("snap_old_val", {25'd0, seg}, {25'd0, 7'b0010010});
        repeat (48) @(posedge clock);
        @(negedge clock);
        check("next_an", {24'd0, an}, 32'h0000_00FE);
        check("next_new_val", {25'd0, seg}, {25'd0, 7'b0010000});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
